// File: rtl/serial_frame_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_transmitter
// Description : One-entry buffered serialiser. Emits WIDTH data bits plus an
//               optional parity bit, with a companion bit clock and done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_transmitter #(
    parameter int WIDTH       = 8,
    parameter int HALF_PERIOD = 1,
    parameter int MSB_FIRST   = 0,
    parameter int PARITY      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             send,
    input  logic [WIDTH-1:0] in_data,
    output logic             ready,
    output logic             transmission,
    output logic             transmission_clock,
    output logic             out_data,
    output logic             done
);

    localparam int c_FRAME_BITS = WIDTH + ((PARITY != 0) ? 1 : 0);
    localparam int c_BIT_CYCLES = 2 * HALF_PERIOD;
    localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 1);
    localparam int c_DIV_W      = $clog2(c_BIT_CYCLES);

    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_FRAME_BITS - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_BIT_CYCLES - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HIGH = c_DIV_W'(HALF_PERIOD);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [0:0]              r_state;
    logic [WIDTH-1:0]        r_hold;
    logic                    r_hold_valid;
    logic [c_FRAME_BITS:0]   r_shift;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [c_DIV_W-1:0]      r_div_cnt;
    logic                    r_ready;
    logic                    r_tx;
    logic                    r_tclk;
    logic                    r_out;
    logic                    r_done;

    logic [WIDTH-1:0]        w_ordered;
    logic [c_FRAME_BITS:0]   w_frame;
    logic                    w_accept;
    logic                    w_period_end;
    logic                    w_frame_end;
    logic                    w_load;
    logic                    w_hold_valid_next;
    logic [c_DIV_W-1:0]      w_div_inc;

    // Frame image is arranged so bit 0 goes on the line first.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
        if (MSB_FIRST != 0) begin : g_msb
            assign w_ordered[gi] = r_hold[WIDTH-1-gi];
        end else begin : g_lsb
            assign w_ordered[gi] = r_hold[gi];
        end
    end

    if (PARITY != 0) begin : g_par
        logic w_parity;
        assign w_parity = (PARITY == 1) ? ^r_hold : ~^r_hold;
        assign w_frame  = {1'b0, w_parity, w_ordered};
    end else begin : g_nopar
        assign w_frame = {1'b0, w_ordered};
    end

    assign w_accept     = send && r_ready;
    assign w_period_end = (r_state == c_SHIFT) && (r_div_cnt == c_DIV_LAST);
    assign w_frame_end  = w_period_end && (r_bit_cnt == c_LAST_BIT);
    assign w_load       = r_hold_valid && ((r_state == c_IDLE) || w_frame_end);
    assign w_div_inc    = r_div_cnt + 1'b1;

    // Accept and load are mutually exclusive: accept needs an empty holder.
    always_comb begin
        w_hold_valid_next = r_hold_valid;
        if (w_accept) begin
            w_hold_valid_next = 1'b1;
        end else if (w_load) begin
            w_hold_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_div_cnt    <= '0;
            r_tx         <= 1'b0;
            r_tclk       <= 1'b0;
            r_out        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_hold_valid <= w_hold_valid_next;
            r_ready      <= !w_hold_valid_next;
            if (w_accept) begin
                r_hold <= in_data;
            end

            if (w_load) begin
                r_state   <= c_SHIFT;
                r_out     <= w_frame[0];
                r_shift   <= w_frame >> 1;
                r_bit_cnt <= '0;
                r_div_cnt <= '0;
                r_tx      <= 1'b1;
                r_tclk    <= 1'b0;
                r_done    <= 1'b0;
            end else if (w_frame_end) begin
                r_state   <= c_IDLE;
                r_out     <= 1'b0;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_div_cnt <= '0;
                r_tx      <= 1'b0;
                r_tclk    <= 1'b0;
                r_done    <= 1'b0;
            end else if (w_period_end) begin
                r_out     <= r_shift[0];
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_div_cnt <= '0;
                r_tclk    <= 1'b0;
                r_done    <= 1'b0;
            end else if (r_state == c_SHIFT) begin
                r_div_cnt <= w_div_inc;
                r_tclk    <= (w_div_inc >= c_DIV_HIGH);
                // Strobe lands on the final cycle of the final bit period.
                r_done    <= (w_div_inc == c_DIV_LAST) && (r_bit_cnt == c_LAST_BIT);
            end
        end
    end

    assign ready              = r_ready;
    assign transmission       = r_tx;
    assign transmission_clock = r_tclk;
    assign out_data           = r_out;
    assign done               = r_done;

endmodule
`default_nettype wire
